// File: rtl/logic_slice_sequencer.sv
// rtl/logic_slice_sequencer.sv - runs a wide bitwise op through one shared narrow logic slice, LSB slice first
module logic_slice_sequencer #(
    parameter int DATA_W  = 16,
    parameter int SLICE_W = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               req_valid,
    output logic               req_ready,
    input  logic [1:0]         req_op,
    input  logic [DATA_W-1:0]  req_a,
    input  logic [DATA_W-1:0]  req_b,
    output logic               slice_valid,
    output logic [1:0]         slice_op,
    output logic [SLICE_W-1:0] slice_a,
    output logic [SLICE_W-1:0] slice_b,
    input  logic [SLICE_W-1:0] slice_result,
    output logic               resp_valid,
    input  logic               resp_ready,
    output logic [DATA_W-1:0]  resp_result,
    output logic               resp_zero,
    output logic               busy
);
    localparam int NSLICE = DATA_W / SLICE_W;
    localparam int IDX_W  = (NSLICE > 1) ? $clog2(NSLICE) : 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t              state;
    logic [IDX_W-1:0]    idx;
    logic [IDX_W-1:0]    nxt_idx;
    logic [DATA_W-1:0]   a_q;
    logic [DATA_W-1:0]   b_q;
    logic [1:0]          op_q;
    logic [DATA_W-1:0]   result;
    logic [DATA_W-1:0]   merged;

    assign req_ready   = (state == IDLE);
    assign resp_result = result;
    assign nxt_idx     = idx + 1'b1;

    // Result as it will look after this edge's capture; feeds resp_zero on the final slice.
    always_comb begin
        merged = result;
        merged[idx*SLICE_W +: SLICE_W] = slice_result;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            idx         <= '0;
            a_q         <= '0;
            b_q         <= '0;
            op_q        <= '0;
            result      <= '0;
            slice_valid <= 1'b0;
            slice_op    <= '0;
            slice_a     <= '0;
            slice_b     <= '0;
            resp_valid  <= 1'b0;
            resp_zero   <= 1'b0;
            busy        <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        a_q         <= req_a;
                        b_q         <= req_b;
                        op_q        <= req_op;
                        result      <= '0;
                        idx         <= '0;
                        state       <= RUN;
                        slice_valid <= 1'b1;
                        slice_op    <= req_op;
                        slice_a     <= req_a[SLICE_W-1:0];
                        slice_b     <= req_b[SLICE_W-1:0];
                        busy        <= 1'b1;
                    end
                end
                RUN: begin
                    result <= merged;
                    if (idx == IDX_W'(NSLICE - 1)) begin
                        state       <= DONE;
                        slice_valid <= 1'b0;
                        slice_op    <= '0;
                        slice_a     <= '0;
                        slice_b     <= '0;
                        resp_valid  <= 1'b1;
                        resp_zero   <= (merged == '0);
                    end else begin
                        idx      <= nxt_idx;
                        slice_op <= op_q;
                        slice_a  <= a_q[nxt_idx*SLICE_W +: SLICE_W];
                        slice_b  <= b_q[nxt_idx*SLICE_W +: SLICE_W];
                    end
                end
                DONE: begin
                    if (resp_ready) begin
                        state      <= IDLE;
                        resp_valid <= 1'b0;
                        resp_zero  <= 1'b0;
                        busy       <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_logic_slice_sequencer.sv
// tb/tb_logic_slice_sequencer.sv - self-checking bench for logic_slice_sequencer
module tb_logic_slice_sequencer;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic [1:0]  req_op;
    logic [15:0] req_a;
    logic [15:0] req_b;
    logic        slice_valid;
    logic [1:0]  slice_op;
    logic [3:0]  slice_a;
    logic [3:0]  slice_b;
    logic [3:0]  slice_result;
    logic        resp_valid;
    logic        resp_ready;
    logic [15:0] resp_result;
    logic        resp_zero;
    logic        busy;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    logic_slice_sequencer #(.DATA_W(16), .SLICE_W(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
        .req_a(req_a), .req_b(req_b),
        .slice_valid(slice_valid), .slice_op(slice_op),
        .slice_a(slice_a), .slice_b(slice_b), .slice_result(slice_result),
        .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_result(resp_result), .resp_zero(resp_zero), .busy(busy)
    );

    // The shared 4-bit gate slice the controller drives.
    always_comb begin
        case (slice_op)
            2'b00:   slice_result = slice_a & slice_b;
            2'b01:   slice_result = slice_a | slice_b;
            2'b10:   slice_result = ~(slice_a | slice_b);
            default: slice_result = slice_a ^ slice_b;
        endcase
    end

    function automatic logic [15:0] ref_op(input logic [1:0] op, input logic [15:0] a, input logic [15:0] b);
        case (op)
            2'b00:   return a & b;
            2'b01:   return a | b;
            2'b10:   return ~(a | b);
            default: return a ^ b;
        endcase
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h want %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Issues one request and waits for resp_valid, recording the slice_a sequence.
    task automatic run_txn(input logic [1:0] op, input logic [15:0] a, input logic [15:0] b,
                           output logic [15:0] res, output logic zero, output int lat,
                           output logic [31:0] seq, output int nval, output logic opok);
        check("req_ready_before", 32'(req_ready), 32'd1);
        req_op = op; req_a = a; req_b = b; req_valid = 1'b1;
        step();
        req_valid = 1'b0;
        req_a = 16'($urandom); req_b = 16'($urandom); req_op = 2'($urandom);
        lat = 0; seq = '0; nval = 0; opok = 1'b1;
        while (!resp_valid && lat < 20) begin
            if (slice_valid) begin
                if (nval < 8) seq[nval*4 +: 4] = slice_a;
                if (slice_op !== op) opok = 1'b0;
                nval++;
            end
            step();
            lat++;
        end
        res = resp_result;
        zero = resp_zero;
    endtask

    task automatic finish_resp();
        resp_ready = 1'b1;
        step();
        resp_ready = 1'b0;
    endtask

    typedef struct {
        logic [1:0]  op;
        logic [15:0] a;
        logic [15:0] b;
        logic [15:0] exp_res;
        logic        exp_zero;
    } vec_t;

    vec_t vecs[5];

    initial begin
        logic [15:0] res;
        logic        zero;
        int          lat;
        logic [31:0] seq;
        int          nval;
        logic        opok;
        logic [15:0] r0;
        logic [15:0] r1;
        int          acc1;
        int          acc2;
        int          nres;

        vecs[0] = '{2'b10, 16'h0F0F, 16'hF0F0, 16'h0000, 1'b1};
        vecs[1] = '{2'b00, 16'h1234, 16'hFF00, 16'h1200, 1'b0};
        vecs[2] = '{2'b01, 16'h1234, 16'hFF00, 16'hFF34, 1'b0};
        vecs[3] = '{2'b11, 16'h1234, 16'hFF00, 16'hED34, 1'b0};
        vecs[4] = '{2'b11, 16'hFFFF, 16'h0000, 16'hFFFF, 1'b0};

        rst_n = 1'b0; req_valid = 1'b0; req_op = '0; req_a = '0; req_b = '0; resp_ready = 1'b0;
        repeat (3) step();
        @(negedge clk) rst_n = 1'b1;
        #1;
        check("rst_req_ready", 32'(req_ready), 32'd1);
        check("rst_resp_valid", 32'(resp_valid), 32'd0);
        check("rst_slice_valid", 32'(slice_valid), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_slice_ab", 32'({slice_a, slice_b, slice_op}), 32'd0);
        check("rst_resp", 32'({resp_result, resp_zero}), 32'd0);

        // Idle quiescence.
        for (int i = 0; i < 6; i++) begin
            resp_ready = i[0];
            step();
            check("idle_quiet", 32'({resp_valid, slice_valid, busy}), 32'd0);
        end
        resp_ready = 1'b0;

        for (int i = 0; i < 5; i++) begin
            run_txn(vecs[i].op, vecs[i].a, vecs[i].b, res, zero, lat, seq, nval, opok);
            check($sformatf("vec%0d_result", i), 32'(res), 32'(vecs[i].exp_res));
            check($sformatf("vec%0d_zero", i), 32'(zero), 32'(vecs[i].exp_zero));
            check($sformatf("vec%0d_latency", i), 32'(lat), 32'd4);
            check($sformatf("vec%0d_slice_cnt", i), 32'(nval), 32'd4);
            check($sformatf("vec%0d_slice_a_seq", i), seq, 32'(vecs[i].a));
            check($sformatf("vec%0d_slice_op", i), 32'(opok), 32'd1);
            finish_resp();
            check($sformatf("vec%0d_idle_after", i), 32'(req_ready), 32'd1);
        end

        // Backpressure in DONE with an ignored request pulse.
        run_txn(2'b00, 16'h1234, 16'hFF00, res, zero, lat, seq, nval, opok);
        for (int i = 0; i < 5; i++) begin
            if (i == 2) begin
                req_valid = 1'b1; req_a = 16'hAAAA; req_b = 16'h5555; req_op = 2'b01;
            end
            step();
            req_valid = 1'b0;
            check("bp_resp_valid", 32'(resp_valid), 32'd1);
            check("bp_resp_result", 32'(resp_result), 32'h1200);
            check("bp_req_ready", 32'(req_ready), 32'd0);
        end
        finish_resp();
        check("bp_idle", 32'(req_ready), 32'd1);
        step();
        check("bp_pulse_ignored", 32'({busy, slice_valid, resp_valid}), 32'd0);

        // Back-to-back with req_valid and resp_ready held high.
        acc1 = -1; acc2 = -1; nres = 0; r0 = '0; r1 = '0;
        req_op = 2'b11; req_a = 16'hC3A5; req_b = 16'h0FF0; req_valid = 1'b1; resp_ready = 1'b1;
        for (int k = 0; k < 24 && nres < 2; k++) begin
            if (req_ready && req_valid) begin
                if (acc1 < 0) acc1 = k;
                else if (acc2 < 0) acc2 = k;
            end
            if (resp_valid) begin
                if (nres == 0) r0 = resp_result; else r1 = resp_result;
                nres++;
            end
            step();
            if (k == acc1) begin req_op = 2'b10; req_a = 16'h1357; req_b = 16'h2468; end
            if (k == acc2) req_valid = 1'b0;
        end
        req_valid = 1'b0; resp_ready = 1'b0;
        check("b2b_nres", 32'(nres), 32'd2);
        check("b2b_spacing", 32'(acc2 - acc1), 32'd6);
        check("b2b_res0", 32'(r0), 32'(ref_op(2'b11, 16'hC3A5, 16'h0FF0)));
        check("b2b_res1", 32'(r1), 32'(ref_op(2'b10, 16'h1357, 16'h2468)));
        step();

        // Asynchronous reset after two captures.
        req_op = 2'b00; req_a = 16'hA5C3; req_b = 16'h3C5A; req_valid = 1'b1;
        step();
        req_valid = 1'b0;
        step(); step();
        #2 rst_n = 1'b0;
        #1;
        check("arst_busy", 32'(busy), 32'd0);
        check("arst_slice", 32'({slice_valid, slice_op, slice_a, slice_b}), 32'd0);
        check("arst_resp", 32'({resp_valid, resp_zero, resp_result}), 32'd0);
        @(negedge clk) rst_n = 1'b1;
        step();
        check("arst_req_ready", 32'(req_ready), 32'd1);
        run_txn(2'b11, 16'hFFFF, 16'h0000, res, zero, lat, seq, nval, opok);
        check("arst_next_result", 32'(res), 32'hFFFF);
        finish_resp();

        // Randomised operations against the word-level model.
        for (int i = 0; i < 30; i++) begin
            logic [1:0]  op;
            logic [15:0] a;
            logic [15:0] b;
            logic [15:0] e;
            op = 2'($urandom); a = 16'($urandom); b = 16'($urandom);
            if (i % 7 == 0) b = a;
            e = ref_op(op, a, b);
            run_txn(op, a, b, res, zero, lat, seq, nval, opok);
            repeat ($urandom_range(0, 3)) step();
            check($sformatf("rnd%0d_result", i), 32'(resp_result), 32'(e));
            check($sformatf("rnd%0d_zero", i), 32'(resp_zero), 32'(e == 16'h0));
            check($sformatf("rnd%0d_latency", i), 32'(lat), 32'd4);
            finish_resp();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout got running want finished");
        $fatal(1);
    end
endmodule
